// File: rtl/lcd_ctrl.sv
// HD44780-style write-only LCD timing engine: byte handshake in, RS/EN/DATA waveforms out.
// Optional power-up init sequence enabled by defining LCD_INIT_EN.
module lcd_ctrl #(
    parameter int T_SETUP = 4,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000,
    parameter int T_PWRUP = 750000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rs_i,
    input  logic [7:0] req_data_i,
    input  logic       lcd_on_i,
    output logic [7:0] lcd_data_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_en_o,
    output logic       lcd_on_o,
    output logic       busy_o,
    output logic       init_done_o
);

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = f_max(f_max(f_max(T_SETUP, T_EN), f_max(T_HOLD, T_CMD)),
                                 f_max(T_CLR, T_PWRUP));
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP);
    localparam logic [CW-1:0] C_EN    = CW'(T_EN);
    localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD);
    localparam logic [CW-1:0] C_CMD   = CW'(T_CMD);
    localparam logic [CW-1:0] C_CLR   = CW'(T_CLR);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PWRUP     = 3'd1,
        S_INIT_LOAD = 3'd2,
        S_SETUP     = 3'd3,
        S_PULSE     = 3'd4,
        S_HOLD      = 3'd5,
        S_WAIT      = 3'd6
    } state_t;

`ifdef LCD_INIT_EN
    localparam state_t        S_RESET = S_PWRUP;
    localparam logic [CW-1:0] C_RESET = CW'(T_PWRUP);

    function automatic logic [7:0] f_init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            2'd3:    return 8'h01;
            default: return 8'h01;
        endcase
    endfunction

    logic [1:0] r_init_idx;
    logic [1:0] w_init_idx_nxt;
    logic       w_lat_init;
`else
    localparam state_t        S_RESET = S_IDLE;
    localparam logic [CW-1:0] C_RESET = '0;
`endif

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_lat_req;
    logic          w_is_clr;

    logic [7:0]    r_data;
    logic [7:0]    w_data_nxt;
    logic          r_rs;
    logic          w_rs_nxt;
    logic          r_en;
    logic          w_en_nxt;
    logic          r_ready;
    logic          w_ready_nxt;
    logic          r_busy;
    logic          r_init_done;
    logic          w_done_nxt;
    logic          r_lcd_on;

    // Clear/home need the long execution wait.
    assign w_is_clr = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) || (r_data == 8'h03));

    // State register and phase counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_RESET;
            r_cnt      <= C_RESET;
`ifdef LCD_INIT_EN
            r_init_idx <= 2'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
`ifdef LCD_INIT_EN
            r_init_idx <= w_init_idx_nxt;
`endif
        end
    end

    // Next-state logic; every timed state leaves when the counter reaches one.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_lat_req      = 1'b0;
`ifdef LCD_INIT_EN
        w_lat_init     = 1'b0;
        w_init_idx_nxt = r_init_idx;
`endif
        case (r_state)
            S_IDLE: begin
                if (req_valid_i && r_ready) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = C_SETUP;
                    w_lat_req   = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef LCD_INIT_EN
            S_PWRUP: begin
                if (r_cnt == C_ONE) begin
                    w_state_nxt = S_INIT_LOAD;
                    w_cnt_nxt   = C_ONE;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            S_INIT_LOAD: begin
                w_state_nxt = S_SETUP;
                w_cnt_nxt   = C_SETUP;
                w_lat_init  = 1'b1;
            end
`endif
            S_SETUP: begin
                if (r_cnt == C_ONE) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = C_EN;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            S_PULSE: begin
                if (r_cnt == C_ONE) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = C_HOLD;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            S_HOLD: begin
                if (r_cnt == C_ONE) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = w_is_clr ? C_CLR : C_CMD;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            S_WAIT: begin
                if (r_cnt == C_ONE) begin
`ifdef LCD_INIT_EN
                    if (!r_init_done && (r_init_idx != 2'd3)) begin
                        w_state_nxt    = S_INIT_LOAD;
                        w_cnt_nxt      = C_ONE;
                        w_init_idx_nxt = r_init_idx + 2'd1;
                    end else begin
                        w_state_nxt    = S_IDLE;
                        w_cnt_nxt      = '0;
                    end
`else
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
`endif
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the next state so every pin is a register.
    always_comb begin
        w_en_nxt    = (w_state_nxt == S_PULSE);
        w_ready_nxt = (w_state_nxt == S_IDLE);
        if (w_lat_req) begin
            w_data_nxt = req_data_i;
            w_rs_nxt   = req_rs_i;
`ifdef LCD_INIT_EN
        end else if (w_lat_init) begin
            w_data_nxt = f_init_byte(r_init_idx);
            w_rs_nxt   = 1'b0;
`endif
        end else begin
            w_data_nxt = r_data;
            w_rs_nxt   = r_rs;
        end
`ifdef LCD_INIT_EN
        w_done_nxt = r_init_done || (w_state_nxt == S_IDLE);
`else
        w_done_nxt = 1'b1;
`endif
    end

    // Registered pin drivers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data      <= 8'h00;
            r_rs        <= 1'b0;
            r_en        <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_init_done <= 1'b0;
            r_lcd_on    <= 1'b0;
        end else begin
            r_data      <= w_data_nxt;
            r_rs        <= w_rs_nxt;
            r_en        <= w_en_nxt;
            r_ready     <= w_ready_nxt;
            r_busy      <= !w_ready_nxt;
            r_init_done <= w_done_nxt;
            r_lcd_on    <= lcd_on_i;
        end
    end

    assign req_ready_o = r_ready;
    assign busy_o      = r_busy;
    assign lcd_data_o  = r_data;
    assign lcd_rs_o    = r_rs;
    assign lcd_rw_o    = 1'b0;
    assign lcd_en_o    = r_en;
    assign lcd_on_o    = r_lcd_on;
    assign init_done_o = r_init_done;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: driver pushes expected strobes, a negedge monitor pops and checks.
module tb_lcd_ctrl;

    localparam int P_SETUP = 2;
    localparam int P_EN    = 3;
    localparam int P_HOLD  = 1;
    localparam int P_CMD   = 5;
    localparam int P_CLR   = 20;
    localparam int P_PWRUP = 10;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic       req_rs_i = 1'b0;
    logic [7:0] req_data_i = 8'h00;
    logic       lcd_on_i = 1'b0;
    logic [7:0] lcd_data_o;
    logic       lcd_rs_o;
    logic       lcd_rw_o;
    logic       lcd_en_o;
    logic       lcd_on_o;
    logic       busy_o;
    logic       init_done_o;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_SETUP(P_SETUP), .T_EN(P_EN), .T_HOLD(P_HOLD),
        .T_CMD(P_CMD), .T_CLR(P_CLR), .T_PWRUP(P_PWRUP)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_rs_i(req_rs_i), .req_data_i(req_data_i),
        .lcd_on_i(lcd_on_i),
        .lcd_data_o(lcd_data_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o),
        .lcd_en_o(lcd_en_o), .lcd_on_o(lcd_on_o),
        .busy_o(busy_o), .init_done_o(init_done_o)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         en_cyc;
        int         rdy_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic p_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops one expectation per EN strobe, then checks width, hold and ready return.
    initial begin : monitor
        exp_t p;
        logic prev_en;
        logic prev_rdy;
        int   en_start;
        prev_en  = 1'b0;
        prev_rdy = 1'b0;
        en_start = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                p_valid = 1'b0;
            end else begin
                if (lcd_en_o && !prev_en) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_en: got strobe with data %0h expected none", lcd_data_o);
                    end else begin
                        p = q.pop_front();
                        check("en_data", lcd_data_o, p.data);
                        check("en_rs", lcd_rs_o, p.rs);
                        check("rw_low", lcd_rw_o, 1'b0);
                        if (p.en_cyc >= 0) check("en_cycle", cyc, p.en_cyc);
                        p_valid  = 1'b1;
                        en_start = cyc;
                    end
                end
                if (!lcd_en_o && prev_en && p_valid) begin
                    check("en_width", cyc - en_start, P_EN);
                    check("hold_data", lcd_data_o, p.data);
                end
                if (req_ready_o && !prev_rdy && p_valid) begin
                    if (p.rdy_cyc >= 0) check("ready_cycle", cyc, p.rdy_cyc);
                    p_valid = 1'b0;
                end
            end
            prev_en  = lcd_en_o;
            prev_rdy = req_ready_o;
        end
    end

    // Call at a negedge; rdy_off is the hand-computed accept-to-ready latency.
    task automatic send(input logic rs, input logic [7:0] d, input int rdy_off);
        int budget;
        budget      = 300;
        req_valid_i = 1'b1;
        req_rs_i    = rs;
        req_data_i  = d;
        while (!req_ready_o && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            timeout_fail("send_accept");
        end else begin
            q.push_back('{rs: rs, data: d, en_cyc: cyc + 1 + 2, rdy_cyc: cyc + 1 + rdy_off});
            @(negedge clk);
        end
        req_valid_i = 1'b0;
    endtask

    // Holds valid through the busy period with scrambled data, then presents d2.
    task automatic send_hold(input logic rs, input logic [7:0] d1, input logic [7:0] d2, input int rdy_off);
        int budget;
        budget      = 300;
        req_valid_i = 1'b1;
        req_rs_i    = rs;
        req_data_i  = d1;
        while (!req_ready_o && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        q.push_back('{rs: rs, data: d1, en_cyc: cyc + 1 + 2, rdy_cyc: cyc + 1 + rdy_off});
        @(negedge clk);
        check("busy_after_accept", busy_o, 1'b1);
        budget = 300;
        while (!req_ready_o && budget > 0) begin
            req_data_i = req_data_i ^ 8'h5A;
            req_rs_i   = ~req_rs_i;
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            timeout_fail("hold_ready");
        end else begin
            req_rs_i   = rs;
            req_data_i = d2;
            q.push_back('{rs: rs, data: d2, en_cyc: cyc + 1 + 2, rdy_cyc: cyc + 1 + rdy_off});
            @(negedge clk);
        end
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 500;
        while (!(req_ready_o && q.size() == 0 && !p_valid) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) timeout_fail("wait_idle");
    endtask

    // Call at a negedge with rst_i already high.
    task automatic do_reset();
        int budget;
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready_o, 1'b0);
        check("rst_busy", busy_o, 1'b1);
        check("rst_en", lcd_en_o, 1'b0);
        check("rst_data", lcd_data_o, 8'h00);
        check("rst_rs", lcd_rs_o, 1'b0);
        check("rst_on", lcd_on_o, 1'b0);
        check("rst_done", init_done_o, 1'b0);
`ifdef LCD_INIT_EN
        q.push_back('{rs: 1'b0, data: 8'h38, en_cyc: -1, rdy_cyc: -1});
        q.push_back('{rs: 1'b0, data: 8'h0C, en_cyc: -1, rdy_cyc: -1});
        q.push_back('{rs: 1'b0, data: 8'h06, en_cyc: -1, rdy_cyc: -1});
        q.push_back('{rs: 1'b0, data: 8'h01, en_cyc: -1, rdy_cyc: -1});
        rst_i = 1'b0;
        repeat (P_PWRUP) begin
            @(negedge clk);
            check("pwrup_no_en", lcd_en_o, 1'b0);
        end
        budget = 500;
        while (!req_ready_o && budget > 0) begin
            check("done_with_ready", init_done_o, 1'b0);
            @(negedge clk);
            budget--;
        end
        if (budget == 0) timeout_fail("init_ready");
        check("init_done", init_done_o, 1'b1);
        check("init_queue_drained", q.size(), 0);
`else
        budget = 0;
        rst_i  = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready_o, 1'b1);
        check("post_rst_busy", busy_o, 1'b0);
        check("post_rst_done", init_done_o, 1'b1);
        check("post_rst_budget", budget, 0);
`endif
    endtask

    initial begin : stimulus
        int budget;
        @(negedge clk);
        lcd_on_i = 1'b1;
        do_reset();

        check("on_follow_hi", lcd_on_o, 1'b1);
        lcd_on_i = 1'b0;
        @(negedge clk);
        check("on_follow_lo", lcd_on_o, 1'b0);

        send(1'b1, 8'h41, 11);
        wait_idle();
        send(1'b0, 8'h01, 26);
        wait_idle();
        send(1'b0, 8'h38, 11);
        wait_idle();
        send_hold(1'b1, 8'h42, 8'h43, 11);
        wait_idle();

        // Reset in the middle of an EN pulse.
        send(1'b1, 8'h55, 11);
        budget = 50;
        while (!lcd_en_o && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) timeout_fail("mid_en_wait");
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("mid_rst_en_drop", lcd_en_o, 1'b0);
        do_reset();
        repeat (4) @(negedge clk);

        send(1'b0, 8'h02, 26);
        wait_idle();
        send(1'b0, 8'h0C, 11);
        wait_idle();
        repeat (5) @(negedge clk);
        check("queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300000");
        $fatal(1, "watchdog");
    end

endmodule
